shifter_extender_pipe: RTL

- Parametrised, pipelined successor to the datapath shifter/extender.
- Performs barrel shifts with carry-out (LSL, LSR, ASR, ROR, double-rotate, RRX) when E=0, and sign/zero extends when E=1.
- Operand width is generic; a valid/ready handshake on both sides allows it to sit between the operand-fetch and ALU stages.
- Fixed two-cycle latency with global stall.

---
 rtl/shifter_pkg.sv | 25 ++
 rtl/shifter_core.sv | 101 ++++++++++
 rtl/shifter_extender_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter/extender.
// Holds the shift and extend operation codes and the width of the op-select field.
package shifter_pkg;

  localparam int T_W = 3;

  typedef enum logic [T_W-1:0] {
    OP_LSL  = 3'd0,
    OP_LSR  = 3'd1,
    OP_ASR  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROR2 = 3'd4,
    OP_RRX  = 3'd5
  } shift_op_e;

  typedef enum logic [T_W-1:0] {
    EXT_SXTB = 3'd0,
    EXT_UXTB = 3'd1,
    EXT_SXTH = 3'd2,
    EXT_UXTH = 3'd3,
    EXT_SX24 = 3'd4,
    EXT_UX12 = 3'd5
  } ext_op_e;

endpackage

// File: rtl/shifter_core.sv
// Combinational shift/rotate/extend datapath.
// Computes the result and carry-out from one registered request.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  input  logic [T_W-1:0]   i_t,
  input  logic             i_e,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout
);

  // Number of amount bits that select a rotate position (amount mod WIDTH).
  localparam int MW = SHW - 1;

  // Widened shifts: the extra bit catches the last bit shifted out, which is
  // the carry. Amounts >= the widened width naturally produce zero/sign fill.
  logic [WIDTH:0]        w_lsl;
  logic [WIDTH:0]        w_lsr;
  logic signed [WIDTH:0] w_asr;
  logic [SHW:0]          w_amt2;
  logic [MW-1:0]         w_rot_amt;
  logic [SHW-1:0]        w_rot_back;
  logic                  w_rot_zero;
  logic [WIDTH-1:0]      w_rot;

  assign w_lsl = {1'b0, i_data} << i_amt;
  assign w_lsr = {i_data, 1'b0} >> i_amt;
  assign w_asr = $signed({i_data, 1'b0}) >>> i_amt;

  // Double-rotate amount is kept at full width so 2*n never wraps before the mod.
  assign w_amt2     = {i_amt, 1'b0};
  assign w_rot_amt  = (i_t == OP_ROR2) ? w_amt2[MW-1:0] : i_amt[MW-1:0];
  assign w_rot_zero = (i_t == OP_ROR2) ? (w_amt2 == '0) : (i_amt == '0);
  assign w_rot_back = SHW'(WIDTH) - {1'b0, w_rot_amt};
  // A zero position shifts left by WIDTH, which contributes nothing.
  assign w_rot      = (i_data >> w_rot_amt) | (i_data << w_rot_back);

  // Operation select; reserved codes fall through to zero with carry passed on.
  always_comb begin
    o_result = '0;
    o_cout   = i_cin;
    if (i_e) begin
      case (i_t)
        EXT_SXTB: o_result = {{(WIDTH-8){i_data[7]}}, i_data[7:0]};
        EXT_UXTB: o_result = {{(WIDTH-8){1'b0}}, i_data[7:0]};
        EXT_SXTH: o_result = {{(WIDTH-16){i_data[15]}}, i_data[15:0]};
        EXT_UXTH: o_result = {{(WIDTH-16){1'b0}}, i_data[15:0]};
        EXT_SX24: o_result = {{(WIDTH-24){i_data[23]}}, i_data[23:0]};
        EXT_UX12: o_result = {{(WIDTH-12){1'b0}}, i_data[11:0]};
        default:  o_result = '0;
      endcase
    end else begin
      case (i_t)
        OP_LSL: begin
          if (i_amt != '0) begin
            o_result = w_lsl[WIDTH-1:0];
            o_cout   = w_lsl[WIDTH];
          end else begin
            o_result = i_data;
          end
        end
        OP_LSR: begin
          if (i_amt != '0) begin
            o_result = w_lsr[WIDTH:1];
            o_cout   = w_lsr[0];
          end else begin
            o_result = i_data;
          end
        end
        OP_ASR: begin
          if (i_amt != '0) begin
            o_result = w_asr[WIDTH:1];
            o_cout   = w_asr[0];
          end else begin
            o_result = i_data;
          end
        end
        OP_ROR, OP_ROR2: begin
          if (!w_rot_zero) begin
            o_result = w_rot;
            o_cout   = w_rot[WIDTH-1];
          end else begin
            o_result = i_data;
          end
        end
        OP_RRX: begin
          o_result = {i_cin, i_data[WIDTH-1:1]};
          o_cout   = i_data[0];
        end
        default: o_result = '0;
      endcase
    end
  end

endmodule

// File: rtl/shifter_extender_pipe.sv
// Two-stage pipelined shifter/extender with valid/ready handshake and global stall.
// Optional macro SHIFTER_STATUS_EN adds registered out_zero/out_neg flags.
module shifter_extender_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shifter_in,
  input  logic [SHW-1:0]   shift_value,
  input  logic [T_W-1:0]   t,
  input  logic             E,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shifter_out,
`ifdef SHIFTER_STATUS_EN
  output logic             cout,
  output logic             out_zero,
  output logic             out_neg
`else
  output logic             cout
`endif
);

  logic             w_adv;
  logic             w_xfer;
  logic [WIDTH-1:0] w_result;
  logic             w_cout;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [SHW-1:0]   r_s1_amt;
  logic [T_W-1:0]   r_s1_t;
  logic             r_s1_e;
  logic             r_s1_cin;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign w_adv    = !r_out_valid | out_ready;
  assign w_xfer   = in_valid & w_adv;
  assign in_ready = w_adv;

  shifter_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .i_data   (r_s1_data),
    .i_amt    (r_s1_amt),
    .i_t      (r_s1_t),
    .i_e      (r_s1_e),
    .i_cin    (r_s1_cin),
    .o_result (w_result),
    .o_cout   (w_cout)
  );

  // Stage 1: capture an accepted request; a bubble enters when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_amt   <= '0;
      r_s1_t     <= '0;
      r_s1_e     <= 1'b0;
      r_s1_cin   <= 1'b0;
    end else begin
      if (w_adv) r_s1_valid <= in_valid;
      if (w_xfer) begin
        r_s1_data <= shifter_in;
        r_s1_amt  <= shift_value;
        r_s1_t    <= t;
        r_s1_e    <= E;
        r_s1_cin  <= cin;
      end
    end
  end

  // Stage 2: register the computed result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_cout      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_s1_valid;
      r_out       <= w_result;
      r_cout      <= w_cout;
    end
  end

  assign out_valid   = r_out_valid;
  assign shifter_out = r_out;
  assign cout        = r_cout;

`ifdef SHIFTER_STATUS_EN
  logic r_zero;
  logic r_neg;

  // Status flags track the stage-2 result register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_adv) begin
      r_zero <= (w_result == '0);
      r_neg  <= w_result[WIDTH-1];
    end
  end

  assign out_zero = r_zero;
  assign out_neg  = r_neg;
`endif

endmodule
